// File: rtl/qam_symbol_demapper.sv
// qam_symbol_demapper: 16-QAM receive-side symbol decision.
// Integrates SPS oversampled I/Q samples per symbol, slices each axis to
// the four 16-QAM levels, maps the decisions to a 4-bit symbol and buffers
// the symbols in a 4-entry first-word-fall-through FIFO with valid/ready out.
// Build option: define QAM_DEMAP_GRAY_EN for Gray mapping per axis
// (-3->00, -1->01, +1->11, +3->10); otherwise natural binary
// (-3->00, -1->01, +1->10, +3->11). Must match the modulator build.
module qam_symbol_demapper #(
  parameter int                SPS  = 8,
  parameter int                SKIP = 16,
  parameter logic signed [17:0] THR = 18'sd8192
) (
  input  logic               axi_clk,
  input  logic               axi_rstn,
  input  logic               demult_valid,
  input  logic signed [17:0] demult_i,
  input  logic signed [17:0] demult_q,
  output logic               dout_valid,
  output logic [3:0]         dout,
  input  logic               dout_ready,
  output logic               aligned,
  output logic               overflow
);

  localparam int LOG2 = $clog2(SPS);
  localparam int AW   = 18 + LOG2;
  localparam logic [LOG2-1:0] CNT_LAST  = LOG2'(SPS - 1);
  localparam logic [7:0]      SKIP_LAST = (SKIP == 0) ? 8'd0 : 8'(SKIP - 1);

  typedef enum logic {
    ST_SKIP  = 1'b0,
    ST_INTEG = 1'b1
  } state_t;

  // With no group delay to discard, reset lands directly in integration.
  localparam state_t ST_RESET = (SKIP == 0) ? ST_INTEG : ST_SKIP;

  // Symbol average: arithmetic shift right by log2(SPS), i.e. floor(sum/SPS).
  function automatic logic signed [17:0] avg_floor(input logic signed [AW-1:0] sum);
    avg_floor = sum[AW-1:LOG2];
  endfunction

  // Four-level decision on one axis, returned as the 2-bit axis code.
  function automatic logic [1:0] slice(input logic signed [17:0] avg);
    logic [1:0] lvl;  // 0:-3  1:-1  2:+1  3:+3
    if (avg >= THR)
      lvl = 2'd3;
    else if (avg >= 18'sd0)
      lvl = 2'd2;
    else if (avg >= -THR)
      lvl = 2'd1;
    else
      lvl = 2'd0;
`ifdef QAM_DEMAP_GRAY_EN
    case (lvl)
      2'd0:    slice = 2'b00;
      2'd1:    slice = 2'b01;
      2'd2:    slice = 2'b11;
      default: slice = 2'b10;
    endcase
`else
    slice = lvl;
`endif
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_skip_cnt;
  logic [LOG2-1:0]        r_samp_cnt;
  logic signed [AW-1:0]   r_acc_i;
  logic signed [AW-1:0]   r_acc_q;
  logic                   r_sym_wr;
  logic [3:0]             r_sym;
  logic [3:0]             r_mem [0:3];
  logic [1:0]             r_wptr;
  logic [1:0]             r_rptr;
  logic [2:0]             r_count;
  logic                   r_overflow;

  logic                   w_integ_smp;
  logic                   w_dump;
  logic signed [AW-1:0]   w_ext_i;
  logic signed [AW-1:0]   w_ext_q;
  logic signed [AW-1:0]   w_sum_i;
  logic signed [AW-1:0]   w_sum_q;
  logic signed [17:0]     w_avg_i;
  logic signed [17:0]     w_avg_q;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;

  // State register: alignment FSM.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn)
      r_state <= ST_RESET;
    else
      r_state <= w_state_nxt;
  end

  // Next state: leave SKIP on the SKIP-th valid sample; INTEG is terminal.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_SKIP && demult_valid && r_skip_cnt == SKIP_LAST)
      w_state_nxt = ST_INTEG;
  end

  // Count discarded samples while skipping.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn)
      r_skip_cnt <= 8'd0;
    else if (r_state == ST_SKIP && demult_valid)
      r_skip_cnt <= r_skip_cnt + 8'd1;
  end

  assign w_integ_smp = demult_valid && (r_state == ST_INTEG);
  assign w_dump      = w_integ_smp && (r_samp_cnt == CNT_LAST);
  assign w_ext_i     = {{LOG2{demult_i[17]}}, demult_i};
  assign w_ext_q     = {{LOG2{demult_q[17]}}, demult_q};
  assign w_sum_i     = r_acc_i + w_ext_i;
  assign w_sum_q     = r_acc_q + w_ext_q;
  assign w_avg_i     = avg_floor(w_sum_i);
  assign w_avg_q     = avg_floor(w_sum_q);

  // Integrate and dump: the last sample of a symbol is folded into the
  // combinational sum and the accumulator restarts from zero.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_samp_cnt <= '0;
    end else if (w_integ_smp) begin
      r_acc_i    <= w_dump ? '0 : w_sum_i;
      r_acc_q    <= w_dump ? '0 : w_sum_q;
      r_samp_cnt <= r_samp_cnt + LOG2'(1);
    end
  end

  // Register the decided symbol and its FIFO write strobe.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_sym_wr <= 1'b0;
      r_sym    <= 4'd0;
    end else begin
      r_sym_wr <= w_dump;
      if (w_dump)
        r_sym <= {slice(w_avg_i), slice(w_avg_q)};
    end
  end

  assign w_full = (r_count == 3'd4);
  assign w_pop  = (r_count != 3'd0) && dout_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = r_sym_wr && (!w_full || w_pop);

  // FIFO storage.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int k = 0; k < 4; k++)
        r_mem[k] <= 4'd0;
    end else if (w_push) begin
      r_mem[r_wptr] <= r_sym;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 2'd1;
      if (w_pop)
        r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a symbol arrived with the FIFO full and nothing leaving.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn)
      r_overflow <= 1'b0;
    else if (r_sym_wr && w_full && !w_pop)
      r_overflow <= 1'b1;
  end

  assign dout_valid = (r_count != 3'd0);
  assign dout       = r_mem[r_rptr];
  assign aligned    = (r_state == ST_INTEG);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_qam_symbol_demapper.sv
// Self-checking bench for qam_symbol_demapper (SPS=8, SKIP=16, THR=8192).
// Expected symbols come from a reference model that collects each symbol's
// samples, averages them with floor division and applies the level rules.
module tb_qam_symbol_demapper;

  localparam int SPS  = 8;
  localparam int SKIP = 16;
  localparam int THR  = 8192;

  logic               axi_clk;
  logic               axi_rstn;
  logic               demult_valid;
  logic signed [17:0] demult_i;
  logic signed [17:0] demult_q;
  logic               dout_valid;
  logic [3:0]         dout;
  logic               dout_ready;
  logic               aligned;
  logic               overflow;

  qam_symbol_demapper #(.SPS(SPS), .SKIP(SKIP), .THR(18'sd8192)) dut (
    .axi_clk      (axi_clk),
    .axi_rstn     (axi_rstn),
    .demult_valid (demult_valid),
    .demult_i     (demult_i),
    .demult_q     (demult_q),
    .dout_valid   (dout_valid),
    .dout         (dout),
    .dout_ready   (dout_ready),
    .aligned      (aligned),
    .overflow     (overflow)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int         m_skip_left;
  int         m_n;
  int         m_buf_i [SPS];
  int         m_buf_q [SPS];
  logic [3:0] exp_q [$];

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && (a < 0))
      r = r - 1;
    return r;
  endfunction

  function automatic int level(input int avg);
    if (avg >= THR)  return 3;
    if (avg >= 0)    return 1;
    if (avg >= -THR) return -1;
    return -3;
  endfunction

  function automatic logic [1:0] code(input int lvl);
`ifdef QAM_DEMAP_GRAY_EN
    case (lvl)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
`else
    case (lvl)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
`endif
  endfunction

  function automatic logic [3:0] sym_code(input int li, input int lq);
    return {code(li), code(lq)};
  endfunction

  function automatic int lvl_val(input int lvl);
    return lvl * 4096;
  endfunction

  task automatic model_reset();
    m_skip_left = SKIP;
    m_n = 0;
    exp_q.delete();
  endtask

  task automatic model_sample(input int i, input int q);
    int si, sq;
    if (m_skip_left > 0) begin
      m_skip_left--;
      return;
    end
    m_buf_i[m_n] = i;
    m_buf_q[m_n] = q;
    m_n++;
    if (m_n == SPS) begin
      si = 0; sq = 0;
      for (int k = 0; k < SPS; k++) begin
        si += m_buf_i[k];
        sq += m_buf_q[k];
      end
      exp_q.push_back(sym_code(level(floor_div(si, SPS)), level(floor_div(sq, SPS))));
      m_n = 0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare any pop against the model at
  // the falling edge, then return 1 time unit after the rising edge.
  task automatic step(input logic v, input int i, input int q);
    demult_valid = v;
    demult_i     = 18'(i);
    demult_q     = 18'(q);
    if (v)
      model_sample(i, q);
    @(negedge axi_clk);
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got dout=%b, expected no symbol", dout);
      end else begin
        check("pop_order", int'(dout), int'(exp_q.pop_front()));
      end
    end
    @(posedge axi_clk);
    #1;
    demult_valid = 1'b0;
  endtask

  task automatic send_sym(input int i, input int q);
    for (int k = 0; k < SPS; k++)
      step(1'b1, i, q);
  endtask

  task automatic do_reset();
    axi_rstn     = 1'b0;
    demult_valid = 1'b0;
    demult_i     = '0;
    demult_q     = '0;
    dout_ready   = 1'b0;
    repeat (2) @(posedge axi_clk);
    #1;
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_aligned", int'(aligned), 0);
    check("rst_overflow", int'(overflow), 0);
    axi_rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int ia; int ib; int qa; int qb; int li; int lq;
  } vec_t;

  vec_t tbl [7];
  int   bp_li [5];
  int   bp_lq [5];

  initial begin
    // I threshold edges with Q=4096, then an integrate-over-noise symbol.
    tbl[0] = '{ 8192,  8192, 4096, 4096,  3,  1};
    tbl[1] = '{ 8191,  8191, 4096, 4096,  1,  1};
    tbl[2] = '{    0,     0, 4096, 4096,  1,  1};
    tbl[3] = '{   -1,    -1, 4096, 4096, -1,  1};
    tbl[4] = '{-8192, -8192, 4096, 4096, -1,  1};
    tbl[5] = '{-8193, -8193, 4096, 4096, -3,  1};
    tbl[6] = '{14000, 10576, -1000, -7192, 3, -1};
    bp_li = '{3, 1, -1, -3, 1};
    bp_lq = '{3, -1, 1, -3, 1};

    do_reset();

    // Alignment: 16 skipped samples, then one symbol.
    dout_ready = 1'b1;
    for (int k = 1; k <= SKIP; k++) begin
      step(1'b1, -12288, -12288);
      if (k == SKIP - 1) check("aligned_before", int'(aligned), 0);
      if (k == SKIP)     check("aligned_after", int'(aligned), 1);
    end
    send_sym(12288, -4096);
    check("latency_t1_valid", int'(dout_valid), 0);
    step(1'b0, 0, 0);
    check("latency_t2_valid", int'(dout_valid), 1);
    check("align_sym", int'(dout), int'(sym_code(3, -1)));
    step(1'b0, 0, 0);
    check("single_symbol", int'(dout_valid), 0);

    // Table of threshold-edge and noise symbols.
    for (int n = 0; n < 7; n++) begin
      for (int k = 0; k < SPS; k++)
        step(1'b1, (k % 2 == 0) ? tbl[n].ia : tbl[n].ib,
                   (k % 2 == 0) ? tbl[n].qa : tbl[n].qb);
      step(1'b0, 0, 0);
      check($sformatf("table%0d_dout", n), int'(dout), int'(sym_code(tbl[n].li, tbl[n].lq)));
      step(1'b0, 0, 0);
      check($sformatf("table%0d_drained", n), int'(dout_valid), 0);
    end

    // Backpressure: five symbols with no consumer, the fifth is dropped.
    dout_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      send_sym(lvl_val(bp_li[s]), lvl_val(bp_lq[s]));
      step(1'b0, 0, 0);
      step(1'b0, 0, 0);
      if (s == 3) check("bp_no_overflow_at4", int'(overflow), 0);
    end
    void'(exp_q.pop_back());
    check("bp_overflow", int'(overflow), 1);
    check("bp_head_held", int'(dout), int'(sym_code(bp_li[0], bp_lq[0])));
    dout_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 0, 0);
      if (k == 3) check("bp_drain3_valid", int'(dout_valid), 1);
      if (k == 4) check("bp_drain4_empty", int'(dout_valid), 0);
    end
    check("bp_model_empty", exp_q.size(), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int k = 0; k < SKIP; k++)
      step(1'b1, 0, 0);
    for (int s = 0; s < 4; s++)
      send_sym(lvl_val(bp_li[s]), lvl_val(bp_lq[s]));
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    send_sym(lvl_val(-3), lvl_val(3));
    dout_ready = 1'b1;
    step(1'b0, 0, 0);
    dout_ready = 1'b0;
    check("full_pushpop_overflow", int'(overflow), 0);
    check("full_pushpop_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 0, 0);
      if (k == 3) check("full_occ_valid3", int'(dout_valid), 1);
      if (k == 4) check("full_occ_empty4", int'(dout_valid), 0);
    end
    check("full_model_empty", exp_q.size(), 0);

    // Reset in the middle of a symbol with two symbols buffered.
    dout_ready = 1'b0;
    send_sym(lvl_val(3), lvl_val(-3));
    send_sym(lvl_val(-1), lvl_val(1));
    for (int k = 0; k < 3; k++)
      step(1'b1, 12288, 12288);
    axi_rstn = 1'b0;
    #2;
    check("midrst_valid", int'(dout_valid), 0);
    check("midrst_aligned", int'(aligned), 0);
    check("midrst_overflow", int'(overflow), 0);
    @(posedge axi_clk);
    #1;
    axi_rstn = 1'b1;
    model_reset();

    // Randomized run after reset: re-skip, gaps and random backpressure.
    for (int k = 0; k < 1500; k++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 85)
        step(1'b1, int'($urandom_range(0, 32767)) - 16384,
                   int'($urandom_range(0, 32767)) - 16384);
      else
        step(1'b0, 0, 0);
      if (k == SKIP + 40) check("rand_realigned", int'(aligned), 1);
    end
    dout_ready = 1'b1;
    for (int k = 0; k < 12; k++)
      step(1'b0, 0, 0);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_dout_valid", int'(dout_valid), 0);
    check("rand_overflow", int'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_demapper.md
# qam_symbol_demapper

Receive-side symbol decision block for the 16-QAM link. Consumes the oversampled baseband I/Q stream from the demodulator (5Q12, one sample per `demult_valid`), integrates each symbol period, slices I and Q to the four 16-QAM levels and maps the result back to the 4-bit symbol. It is the inverse of the modulator's bit-to-symbol mapping. Symbols leave through a valid/ready port buffered by a 4-entry FIFO.

## Interface
- `SPS`, default 8: samples per symbol; must be a power of 2, range 2..64.
- `SKIP`, default 16: valid samples discarded after reset, for filter group-delay alignment; range 0..255.
- `THR`, default 18'sd8192 (2.0 in 5Q12): outer decision threshold.
- `axi_clk`, input, 1: clock; all logic on the rising edge.
- `axi_rstn`, input, 1: asynchronous active-low reset.
- `demult_valid`, input, 1: sample strobe; no backpressure.
- `demult_i`, input, 18 signed: in-phase sample, 5Q12.
- `demult_q`, input, 18 signed: quadrature sample, 5Q12.
- `dout_valid`, output, 1: FIFO head holds a symbol.
- `dout`, output, 4: symbol. `[3:2]` carries the I decision and `[1:0]` carries the Q decision.
- `dout_ready`, input, 1: consumer accepts `dout` when high together with `dout_valid`.
- `aligned`, output, 1: high once skipping is finished (state INTEG).
- `overflow`, output, 1: sticky flag, set when a symbol is dropped because the FIFO is full.

## Operation
- FSM states:
  - SKIP (entered on reset): counts valid samples. When SKIP samples have been counted, moves to INTEG. If `SKIP==0`, reset goes directly to INTEG.
  - INTEG: never left except by reset.
- In INTEG, each valid sample does the following:
  - `acc_i += demult_i` and `acc_q += demult_q`. Accumulators are 18+log2(SPS) bits wide and signed, with no saturation needed.
  - `samp_cnt` increments, wrapping from SPS-1 to 0.
- Dump happens on the sample where `samp_cnt==SPS-1`:
  - `sum = acc + sample`, computed combinationally.
  - `avg = sum >>> log2(SPS)` (arithmetic shift, floor).
  - The accumulator is cleared to 0 in the same cycle. The next symbol's first sample starts from 0.
- Slicer, applied to I and Q independently:
  - `avg >= THR` → +3
  - `0 <= avg < THR` → +1
  - `-THR <= avg < 0` → -1
  - `avg < -THR` → -3
  - Boundary values: exactly THR → +3; exactly 0 → +1; exactly -THR → -1.
- The 4-bit symbol and a write pulse are registered (`sym_wr`), then written into the FIFO on the next edge.
- FIFO:
  - Depth 4, first-word fall-through.
  - Pop condition: `dout_valid && dout_ready`.
  - Push when full and no pop in the same cycle: the symbol is dropped and `overflow` is set to 1.
  - Push and pop in the same cycle while full: both happen, occupancy stays 4, no overflow.
  - Push and pop while empty is not possible, because the push only becomes visible on the next cycle.
- `demult_valid` low: nothing changes; gaps between samples are allowed anywhere.

## Timing
- Reset values: `dout_valid=0`, `dout=4'b0000`, `aligned=0` (1 if `SKIP==0`), `overflow=0`.
  - Accumulators, counters, `sym_wr` and FIFO pointers are all reset to 0.
  - State is SKIP (INTEG if `SKIP==0`).
- Latency: the last sample of a symbol is valid in cycle t.
  - `sym_wr` is high in t+1.
  - The FIFO write occurs at the end of t+1.
  - `dout_valid` goes high in t+2 if the FIFO was empty.
- `aligned` rises in the cycle after the SKIP-th valid sample.
- `dout` is stable while `dout_valid && !dout_ready`.
- Reset asserted mid-symbol or mid-FIFO: everything returns to reset values immediately. Partial sums and buffered symbols are lost.
- Maximum throughput: one symbol per SPS cycles. The block needs no stall at `SPS>=2`.

## Configuration
- `QAM_DEMAP_GRAY_EN` defined: Gray mapping per axis, -3→00, -1→01, +1→11, +3→10.
- `QAM_DEMAP_GRAY_EN` undefined: natural binary per axis, -3→00, -1→01, +1→10, +3→11.
- The setting must match the modulator's mapping build option.

## Test plan
- Alignment (SKIP=16, SPS=8, Gray): 16 samples of I=-12288, Q=-12288 are sent, then 8 samples of I=12288, Q=-4096 → exactly one symbol `dout=4'b1001`, `dout_valid` two cycles after the 8th sample, `aligned` high after the 16th sample.
- Threshold edges:
  - Symbols with constant avg I = 8192, 8191, 0, -1, -8192, -8193 and Q=4096 → I decisions +3, +1, +1, -1, -1, -3.
  - Gray dout values: 1011, 1111, 1111, 0111, 0111, 0011.
- Integrate over noise: 8 samples with I alternating 14000/10576 (avg 12288) and Q alternating -1000/-7192 (avg -4096) → `4'b1001`.
- Backpressure/overflow: `dout_ready=0` for 5 symbols → first 4 are held in order and `overflow=1` after the 5th. Then `dout_ready=1` → the 4 buffered symbols drain, one per cycle.
- Full push/pop: FIFO at 4 entries, `dout_ready=1` in the cycle `sym_wr` is high → occupancy stays 4 and `overflow` stays 0.
- Reset mid-operation: `axi_rstn` is pulsed low after 3 samples of a symbol with 2 symbols buffered → `dout_valid=0`, `aligned=0`. A new run re-skips 16 samples and outputs correct symbols.
